// File: rtl/mydithering_param_if.sv
// Pixel write bus between the dithering engine and the display memory.
interface mydithering_param_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              de_req;
    logic              de_ack;
    logic [ADDR_W-1:0] de_addr;
    logic [3:0]        de_nbyte;
    logic              de_rnw;
    logic [31:0]       de_w_data;
    logic [31:0]       de_r_data;

    modport master (
        output de_req, de_addr, de_nbyte, de_rnw, de_w_data,
        input  de_ack, de_r_data
    );

    modport slave (
        input  de_req, de_addr, de_nbyte, de_rnw, de_w_data,
        output de_ack, de_r_data
    );
endinterface

// File: rtl/mydithering_param.sv
// Rectangle fill engine: quantises a colour to RGB332-style pixels, optionally with
// Floyd-Steinberg error diffusion, and writes one byte lane per pixel.
module mydithering_param #(
    parameter int unsigned R_BITS    = 3,
    parameter int unsigned G_BITS    = 3,
    parameter int unsigned B_BITS    = 2,
    parameter int unsigned MAX_WIDTH = 640,
    parameter int unsigned STRIDE    = 640,
    parameter int unsigned ADDR_W    = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    output logic        busy,
    output logic        fault,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    mydithering_param_if.master de
);
    localparam int unsigned AW = ADDR_W + 2;
    localparam int unsigned CW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

    state_e state_q, state_d;

    logic        ack_q, fault_q, mode_q, first_row_q;
    logic [15:0] x_start_q, y_start_q, x_end_q, y_end_q, x_q, y_q;
    logic [7:0]  colour_q [3];
    logic [CW-1:0] col_q;

    // Diffusion state in 1/16 units: right carry and two pending below-row sums.
    logic signed [11:0] err_r_q [3];
    logic signed [11:0] acc_a_q [3];
    logic signed [11:0] acc_b_q [3];
    logic signed [11:0] lb [3][MAX_WIDTH];

    logic signed [11:0] sum_c [3], diff_c [3], v_c [3], e_c [3];
    logic [11:0]        qs_c [3];
    logic [7:0]         c_c [3];
    logic [6:0]         q_c [3];
    logic [7:0]         pix;
    logic [AW-1:0]      byte_addr;
    logic               last_col, last_row, bad, pix_acc;

    function automatic int unsigned nbits(input int ch);
        case (ch)
            0:       return R_BITS;
            1:       return G_BITS;
            default: return B_BITS;
        endcase
    endfunction

    function automatic logic [6:0] quant(input logic [7:0] c, input int unsigned n);
        logic [7:0] t;
        logic [7:0] lim;
        t   = (c >> (8 - n)) + {7'd0, c[7 - n]};
        lim = 8'((1 << n) - 1);
        if (t > lim) t = lim;
        return t[6:0];
    endfunction

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            sum_c[ch]  = err_r_q[ch] + (first_row_q ? 12'sd0 : lb[ch][col_q]);
            diff_c[ch] = mode_q ? ((sum_c[ch] + 12'sd8) >>> 4) : 12'sd0;
            v_c[ch]    = $signed({4'b0000, colour_q[ch]}) + diff_c[ch];
            if (v_c[ch] < 12'sd0)        c_c[ch] = 8'h00;
            else if (v_c[ch] > 12'sd255) c_c[ch] = 8'hFF;
            else                         c_c[ch] = v_c[ch][7:0];
            q_c[ch]  = quant(c_c[ch], nbits(ch));
            qs_c[ch] = 12'(q_c[ch]) << (8 - nbits(ch));
            e_c[ch]  = $signed({4'b0000, c_c[ch]}) - $signed(qs_c[ch]);
        end
    end

    assign pix       = {q_c[0][R_BITS-1:0], q_c[1][G_BITS-1:0], q_c[2][B_BITS-1:0]};
    assign byte_addr = AW'(x_q) + AW'(y_q) * AW'(STRIDE);
    assign last_col  = (x_q == x_end_q);
    assign last_row  = (y_q == y_end_q);
    assign pix_acc   = (state_q == StDraw) && de.de_ack;
    assign bad       = (x_end_q < x_start_q) || (y_end_q < y_start_q) ||
                       (({1'b0, x_end_q} - {1'b0, x_start_q} + 17'd1) > 17'(MAX_WIDTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req) state_d = StSetup;
            StSetup: state_d = bad ? StIdle : StDraw;
            StDraw:  if (de.de_ack && last_col && last_row) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
            mode_q      <= 1'b0;
            first_row_q <= 1'b1;
            x_start_q   <= '0;
            y_start_q   <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                colour_q[ch] <= '0;
                err_r_q[ch]  <= '0;
                acc_a_q[ch]  <= '0;
                acc_b_q[ch]  <= '0;
            end
        end else begin
            ack_q <= (state_q == StIdle) && req;
            if (state_q == StIdle && req) begin
                fault_q     <= 1'b0;
                x_start_q   <= r0;
                y_start_q   <= r1;
                x_end_q     <= r2;
                y_end_q     <= r3;
                colour_q[0] <= r4[15:8];
                colour_q[1] <= r4[7:0];
                colour_q[2] <= r5[15:8];
                mode_q      <= r6[0];
                x_q         <= r0;
                y_q         <= r1;
            end
            if (state_q == StSetup) begin
                if (bad) fault_q <= 1'b1;
                first_row_q <= 1'b1;
                col_q       <= '0;
                for (int ch = 0; ch < 3; ch++) begin
                    err_r_q[ch] <= '0;
                    acc_a_q[ch] <= '0;
                    acc_b_q[ch] <= '0;
                end
            end
            if (pix_acc) begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (last_col) begin
                        err_r_q[ch] <= '0;
                        acc_a_q[ch] <= '0;
                        acc_b_q[ch] <= '0;
                    end else begin
                        err_r_q[ch] <= e_c[ch] * 12'sd7;
                        acc_b_q[ch] <= acc_a_q[ch] + e_c[ch] * 12'sd5;
                        acc_a_q[ch] <= e_c[ch];
                    end
                end
                if (last_col) begin
                    x_q         <= x_start_q;
                    y_q         <= y_q + 16'd1;
                    col_q       <= '0;
                    first_row_q <= 1'b0;
                end else begin
                    x_q   <= x_q + 16'd1;
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Column col-1 of the next row is final once this pixel adds its below-left share;
    // the last column is closed out in the same cycle.
    always_ff @(posedge clk) begin
        if (pix_acc && !rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (col_q != '0) lb[ch][col_q - CW'(1)] <= acc_b_q[ch] + e_c[ch] * 12'sd3;
                if (last_col)    lb[ch][col_q] <= acc_a_q[ch] + e_c[ch] * 12'sd5;
            end
        end
    end

    assign ack          = ack_q;
    assign busy         = (state_q != StIdle);
    assign fault        = fault_q;
    assign de.de_req    = (state_q == StDraw);
    assign de.de_addr   = byte_addr[AW-1:2];
    assign de.de_nbyte  = ~(4'b0001 << byte_addr[1:0]);
    assign de.de_rnw    = 1'b0;
    assign de.de_w_data = {4{pix}};

    logic unused_bits;
    assign unused_bits = ^{de.de_r_data, r5[7:0], r6[15:1], r7, q_c[0], q_c[1], q_c[2]};
endmodule

// File: tb/tb_mydithering_param.sv
// Directed bench for the dithering rectangle fill engine.
module tb_mydithering_param;
    logic        clk = 1'b0;
    logic        rst, req;
    logic        ack, busy, fault;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] cap_addr [64];
    logic [3:0]  cap_nb   [64];
    logic [31:0] cap_data [64];
    logic        cap_rnw  [64];
    int          cap_n;

    mydithering_param_if #(.ADDR_W(18)) de_bus ();

    mydithering_param #(
        .R_BITS(3), .G_BITS(3), .B_BITS(2),
        .MAX_WIDTH(640), .STRIDE(640), .ADDR_W(18)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy), .fault(fault),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .de(de_bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic start_cmd(input logic [15:0] x0, input logic [15:0] y0,
                             input logic [15:0] x1, input logic [15:0] y1,
                             input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb,
                             input logic md, output logic ack_seen);
        @(negedge clk);
        r0 = x0; r1 = y0; r2 = x1; r3 = y1;
        r4 = {cr, cg}; r5 = {cb, 8'h00}; r6 = {15'd0, md}; r7 = 16'hDEAD;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ack_seen = ack;
    endtask

    task automatic collect(input int n, input int budget);
        cap_n = 0;
        for (int i = 0; i < budget && cap_n < n; i++) begin
            @(negedge clk);
            if (de_bus.de_req && de_bus.de_ack) begin
                cap_addr[cap_n] = de_bus.de_addr;
                cap_nb[cap_n]   = de_bus.de_nbyte;
                cap_data[cap_n] = de_bus.de_w_data;
                cap_rnw[cap_n]  = de_bus.de_rnw;
                cap_n++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b1; de_bus.de_ack = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ack, busy, fault, de_bus.de_req, de_bus.de_rnw} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b need 00000",
                     {ack, busy, fault, de_bus.de_req, de_bus.de_rnw});
        end
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_over_req: busy got %b need 0", busy);
        end
    endtask

    task automatic test_round;
        logic a;
        logic [3:0] exp_nb [2] = '{4'hE, 4'hD};
        de_bus.de_ack = 1'b1;
        start_cmd(16'd0, 16'd0, 16'd1, 16'd0, 8'h30, 8'h30, 8'h30, 1'b0, a);
        n_cmp++;
        if (a !== 1'b1) begin n_bad++; $display("FAIL round_ack: got %b need 1", a); end
        collect(2, 20);
        n_cmp++;
        if (cap_n !== 2) begin n_bad++; $display("FAIL round_count: got %0d need 2", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            n_cmp++;
            if (cap_addr[i] !== 18'd0 || cap_nb[i] !== exp_nb[i] ||
                cap_data[i] !== 32'h49494949 || cap_rnw[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL round_px%0d: got %0d/%h/%h/%b need 0/%h/49494949/0",
                         i, cap_addr[i], cap_nb[i], cap_data[i], cap_rnw[i], exp_nb[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || de_bus.de_req !== 1'b0) begin
            n_bad++;
            $display("FAIL round_idle: busy/de_req got %b%b need 00", busy, de_bus.de_req);
        end
    endtask

    task automatic test_diffusion;
        logic a;
        logic [7:0]  exp_b1 [4] = '{8'h20, 8'h00, 8'h20, 8'h00};
        logic [3:0]  exp_n1 [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0]  exp_b2 [4] = '{8'h20, 8'h00, 8'h00, 8'h20};
        logic [17:0] exp_a2 [4] = '{18'd0, 18'd0, 18'd160, 18'd160};
        de_bus.de_ack = 1'b1;
        start_cmd(16'd0, 16'd0, 16'd3, 16'd0, 8'h10, 8'h00, 8'h00, 1'b1, a);
        collect(4, 20);
        n_cmp++;
        if (cap_n !== 4) begin n_bad++; $display("FAIL diff_row_count: got %0d need 4", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            n_cmp++;
            if (cap_data[i] !== {4{exp_b1[i]}} || cap_addr[i] !== 18'd0 ||
                cap_nb[i] !== exp_n1[i]) begin
                n_bad++;
                $display("FAIL diff_row_px%0d: got %h/%0d/%h need %h/0/%h",
                         i, cap_data[i], cap_addr[i], cap_nb[i], {4{exp_b1[i]}}, exp_n1[i]);
            end
        end
        start_cmd(16'd0, 16'd0, 16'd1, 16'd1, 8'h10, 8'h00, 8'h00, 1'b1, a);
        collect(4, 20);
        n_cmp++;
        if (cap_n !== 4) begin n_bad++; $display("FAIL diff_2row_count: got %0d need 4", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            n_cmp++;
            if (cap_data[i] !== {4{exp_b2[i]}} || cap_addr[i] !== exp_a2[i]) begin
                n_bad++;
                $display("FAIL diff_2row_px%0d: got %h/%0d need %h/%0d",
                         i, cap_data[i], cap_addr[i], {4{exp_b2[i]}}, exp_a2[i]);
            end
        end
    endtask

    task automatic test_saturate;
        logic a;
        logic [17:0] ea;
        de_bus.de_ack = 1'b1;
        start_cmd(16'd0, 16'd0, 16'd7, 16'd7, 8'hFF, 8'hFF, 8'hFF, 1'b1, a);
        collect(64, 200);
        n_cmp++;
        if (cap_n !== 64) begin n_bad++; $display("FAIL sat_count: got %0d need 64", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            ea = 18'(((i / 8) * 640 + (i % 8)) >> 2);
            n_cmp++;
            if (cap_data[i] !== 32'hFFFFFFFF || cap_addr[i] !== ea) begin
                n_bad++;
                $display("FAIL sat_px%0d: got %h/%0d need ffffffff/%0d",
                         i, cap_data[i], cap_addr[i], ea);
            end
        end
    endtask

    task automatic test_edge_addr;
        logic a;
        logic [17:0] exp_a [4] = '{18'd159, 18'd159, 18'd319, 18'd319};
        logic [3:0]  exp_n [4] = '{4'hB, 4'h7, 4'hB, 4'h7};
        de_bus.de_ack = 1'b1;
        start_cmd(16'd638, 16'd0, 16'd639, 16'd1, 8'h30, 8'h30, 8'h30, 1'b0, a);
        collect(4, 20);
        n_cmp++;
        if (cap_n !== 4) begin n_bad++; $display("FAIL edge_count: got %0d need 4", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            n_cmp++;
            if (cap_addr[i] !== exp_a[i] || cap_nb[i] !== exp_n[i]) begin
                n_bad++;
                $display("FAIL edge_px%0d: got %0d/%h need %0d/%h",
                         i, cap_addr[i], cap_nb[i], exp_a[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_reject;
        logic a;
        logic seen_req;
        logic [15:0] bx0 [3] = '{16'd9, 16'd0, 16'd0};
        logic [15:0] by0 [3] = '{16'd0, 16'd3, 16'd0};
        logic [15:0] bx1 [3] = '{16'd5, 16'd0, 16'd640};
        logic [15:0] by1 [3] = '{16'd0, 16'd2, 16'd0};
        de_bus.de_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_cmd(bx0[k], by0[k], bx1[k], by1[k], 8'h30, 8'h30, 8'h30, 1'b0, a);
            n_cmp++;
            if (a !== 1'b1 || (k > 0 && fault !== 1'b0)) begin
                n_bad++;
                $display("FAIL reject%0d_accept: ack/fault got %b%b need 1/0", k, a, fault);
            end
            seen_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (fault !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) begin
                n_bad++;
                $display("FAIL reject%0d_flags: fault/busy/ack got %b%b%b need 100",
                         k, fault, busy, ack);
            end
            repeat (6) begin
                @(negedge clk);
                if (de_bus.de_req) seen_req = 1'b1;
            end
            n_cmp++;
            if (seen_req !== 1'b0 || fault !== 1'b1) begin
                n_bad++;
                $display("FAIL reject%0d_hold: de_req_seen/fault got %b%b need 01",
                         k, seen_req, fault);
            end
        end
    endtask

    task automatic test_stall;
        logic a;
        logic stalled;
        logic [17:0] pa;
        logic [31:0] pd;
        logic [3:0]  pn;
        logic [3:0]  exp_n [3] = '{4'hE, 4'hD, 4'hB};
        int cnt;
        de_bus.de_ack = 1'b0;
        start_cmd(16'd4, 16'd2, 16'd6, 16'd2, 8'hFF, 8'h00, 8'h80, 1'b0, a);
        n_cmp++;
        if (fault !== 1'b0) begin n_bad++; $display("FAIL stall_fault_clr: got %b need 0", fault); end
        cnt = 0; stalled = 1'b0; pa = '0; pd = '0; pn = '0;
        for (int i = 0; i < 40 && cnt < 3; i++) begin
            @(negedge clk);
            de_bus.de_ack = ((i % 3) == 2);
            #1;
            if (de_bus.de_req) begin
                if (stalled) begin
                    n_cmp++;
                    if (de_bus.de_addr !== pa || de_bus.de_w_data !== pd ||
                        de_bus.de_nbyte !== pn) begin
                        n_bad++;
                        $display("FAIL stall_hold: got %0d/%h/%h need %0d/%h/%h",
                                 de_bus.de_addr, de_bus.de_w_data, de_bus.de_nbyte, pa, pd, pn);
                    end
                end
                if (de_bus.de_ack) begin
                    n_cmp++;
                    if (de_bus.de_addr !== 18'd321 || de_bus.de_w_data !== 32'hE2E2E2E2 ||
                        de_bus.de_nbyte !== exp_n[cnt]) begin
                        n_bad++;
                        $display("FAIL stall_px%0d: got %0d/%h/%h need 321/e2e2e2e2/%h", cnt,
                                 de_bus.de_addr, de_bus.de_w_data, de_bus.de_nbyte, exp_n[cnt]);
                    end
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pa = de_bus.de_addr; pd = de_bus.de_w_data; pn = de_bus.de_nbyte;
                end
            end
        end
        n_cmp++;
        if (cnt !== 3) begin n_bad++; $display("FAIL stall_count: got %0d need 3", cnt); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_idle: busy got %b need 0", busy); end
        de_bus.de_ack = 1'b1;
    endtask

    task automatic test_reset_mid_draw;
        logic a;
        logic seen_req;
        de_bus.de_ack = 1'b1;
        start_cmd(16'd0, 16'd0, 16'd3, 16'd3, 8'h30, 8'h30, 8'h30, 1'b1, a);
        collect(3, 20);
        n_cmp++;
        if (cap_n !== 3) begin n_bad++; $display("FAIL rstdraw_count: got %0d need 3", cap_n); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (de_bus.de_req !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
            n_bad++;
            $display("FAIL rstdraw_drop: de_req/busy/ack got %b%b%b need 000",
                     de_bus.de_req, busy, ack);
        end
        rst = 1'b0;
        seen_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (de_bus.de_req || busy) seen_req = 1'b1;
        end
        n_cmp++;
        if (seen_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rstdraw_nowrite: activity got %b need 0", seen_req);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0;
        r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0; r6 = '0; r7 = '0;
        de_bus.de_ack = 1'b0;
        de_bus.de_r_data = 32'h0;
        test_reset();
        test_round();
        test_diffusion();
        test_saturate();
        test_edge_addr();
        test_reject();
        test_stall();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mydithering_param.md
MYDITHERING_PARAM -- requirements
Module: mydithering_param

Interface
REQ-001 SHALL have parameters, one per line below.
REQ-002 R_BITS, 3, output red bits.
REQ-003 G_BITS, 3, output green bits.
REQ-004 B_BITS, 2, output blue bits; R_BITS+G_BITS+B_BITS SHALL equal 8, each 2..6.
REQ-005 MAX_WIDTH, 640, line-buffer depth (max rectangle width).
REQ-006 STRIDE, 640, bytes per screen row.
REQ-007 ADDR_W, 18, word-address width.
REQ-008 SHALL have one clock and a synchronous active-high reset; ports, one per line below.
REQ-009 clk  in  1  clock, all state on rising edge.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 req / ack  in / out  1 / 1  command request / one-cycle acknowledge.
REQ-012 busy  out  1  high outside IDLE.
REQ-013 fault  out  1  last command rejected; held until next accepted req.
REQ-014 r0..r7  in  16 each  r0 x_start, r1 y_start, r2 x_end, r3 y_end, r4[15:8] R, r4[7:0] G, r5[15:8] B, r6[0] mode (0 round, 1 error diffusion), r7 unused.
REQ-015 de_req / de_ack  out / in  1 / 1  pixel write request / accept.
REQ-016 de_addr  out  ADDR_W  word address = pixel byte address >> 2.
REQ-017 de_nbyte  out  4  active-low lane enable: addr[1:0] 0,1,2,3 -> 1110, 1101, 1011, 0111.
REQ-018 de_rnw  out  1  constant 0; de_w_data out 32, pixel byte replicated x4; de_r_data in 32, ignored.

Function
REQ-019 States SHALL be IDLE, SETUP, DRAW; req in IDLE latches r0..r6, pulses ack next cycle, enters SETUP; req outside IDLE ignored.
REQ-020 Command SHALL be rejected if x_end<x_start, y_end<y_start, or width>MAX_WIDTH: ack pulses, fault=1, no de_req, back to IDLE.
REQ-021 SETUP SHALL last one cycle, zero the diffusion state (first-row gating, no multi-cycle clear) and present pixel (x_start,y_start); de_req rises entering DRAW.
REQ-022 de_req, de_addr, de_nbyte, de_w_data SHALL hold stable until de_ack sampled high; one pixel per ack, back-to-back acks give 1 pixel/cycle.
REQ-023 Scan SHALL be raster, left to right, top to bottom; byte address = x + y*STRIDE, no wrap checking.
REQ-024 After ack of (x_end,y_end), de_req SHALL drop and state return to IDLE next cycle.
REQ-025 Per channel of N bits: c = clamp(colour + diffused, 0..255); q = c[7:8-N] + c[7-N], saturated at 2^N-1; pixel = {qR,qG,qB}.
REQ-026 Mode 0: diffused = 0 always.
REQ-027 Mode 1: e = c - (q << (8-N)), signed; Floyd-Steinberg 7/16 right, 3/16 below-left, 5/16 below, 1/16 below-right, accumulated in 1/16 units (at least 12-bit signed) and converted by (sum+8)>>>4.
REQ-028 Error targeting columns outside [x_start,x_end] SHALL be discarded; right error SHALL not carry across row end; row y_start receives no below-error.
REQ-029 Line buffer SHALL hold one entry per column per channel, indexed x - x_start.

Reset
REQ-030 rst SHALL force IDLE; ack, de_req, busy, fault = 0; de_rnw = 0; diffusion state cleared.
REQ-031 rst mid-DRAW SHALL drop de_req next edge; no further writes issued.
REQ-032 rst has priority over req and de_ack in the same cycle.

Verification
REQ-033 Mode 0, R=G=B=0x30, rect (0,0)-(1,0), de_ack tied 1 -> de_addr 0,0; de_nbyte 1110,1101; de_w_data 0x49494949 both; then IDLE.
REQ-034 Mode 1, R=0x10, G=B=0, rect (0,0)-(3,0) -> pixel bytes 0x20,0x00,0x20,0x00.
REQ-035 Mode 1, R=G=B=0xFF, rect 8x8 -> every byte 0xFF, no overflow.
REQ-036 Rect (638,0)-(639,1) -> de_addr 159,159,319,319; de_nbyte 1011,0111,1011,0111.
REQ-037 r2=5, r0=9 -> ack pulse, fault=1, de_req never high.
REQ-038 rst asserted after 3rd ack of 4x4 draw, de_ack held 1 -> de_req 0 next cycle, busy 0, no 4th write.
